// File: rtl/vga_window_timing_gen.sv
// VGA timing generator with a positioned frame-buffer window, colour bars and border overlay.
// State advances on a divided pixel tick; video outputs come out of a two-tick pipeline.
module vga_window_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACT    = 640,
  parameter int V_FRONT  = 11,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 31,
  parameter int V_ACT    = 480,
  parameter int SYNC_POL = 0,
  parameter int WIN_X0   = 100,
  parameter int WIN_Y0   = 50,
  parameter int WIN_W    = 128,
  parameter int WIN_H    = 128,
  parameter int ADDR_W   = 15,
  parameter int BORDER   = 4
) (
  input  logic              clk_n,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [23:0]       pix_data,
  output logic              pix_en,
  output logic              hsync,
  output logic              vsync,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        rgb_r,
  output logic [7:0]        rgb_g,
  output logic [7:0]        rgb_b,
  output logic              frame_start
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_ACT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACT / 8;
  localparam logic SPOL  = (SYNC_POL != 0);

  if (WIN_W * WIN_H > 2 ** ADDR_W) begin : g_addr_check
    $error("vga_window_timing_gen: window does not fit in ADDR_W address bits");
  end

  logic [DW-1:0] div_cnt_reg;
  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic [1:0]    mode_reg;
  logic          tick;

  assign tick       = (div_cnt_reg == DW'(CLK_DIV - 1));
  assign vga_sync_n = 1'b1;

  always_ff @(posedge clk_n or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      pix_en      <= 1'b0;
    end else begin
      pix_en      <= tick;
      div_cnt_reg <= tick ? '0 : div_cnt_reg + DW'(1);
    end
  end

  always_ff @(posedge clk_n or negedge reset) begin
    if (!reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      mode_reg  <= 2'b00;
    end else if (tick) begin
      // mode is latched only at the frame origin so a frame never mixes modes
      if (h_cnt_reg == '0 && v_cnt_reg == '0)
        mode_reg <= mode;
      if (h_cnt_reg == HW'(H_TOTAL - 1)) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= (v_cnt_reg == VW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + VW'(1);
      end else begin
        h_cnt_reg <= h_cnt_reg + HW'(1);
      end
    end
  end

  // Stage 0: decode the current counter position
  logic [31:0] h32, v32, ax32, ay32, wx32, wy32;
  logic        active0, hs0, vs0, fs0, win0, brd0, rd0;
  logic [ADDR_W-1:0] addr0;
  logic [6:0]  bar_edge;
  logic [2:0]  bar0;

  assign h32  = 32'(h_cnt_reg);
  assign v32  = 32'(v_cnt_reg);
  assign ax32 = h32 - H_BLANK;
  assign ay32 = v32 - V_BLANK;
  assign wx32 = ax32 - WIN_X0;
  assign wy32 = ay32 - WIN_Y0;

  assign active0 = (h32 >= H_BLANK) && (v32 >= V_BLANK);
  assign hs0     = (h32 >= H_FRONT) && (h32 < H_FRONT + H_SYNC);
  assign vs0     = (v32 >= V_FRONT) && (v32 < V_FRONT + V_SYNC);
  assign fs0     = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  // ax/ay never exceed the active area, so an off-screen window part is simply clipped
  assign win0    = active0 && (ax32 >= WIN_X0) && (ax32 < WIN_X0 + WIN_W) &&
                   (ay32 >= WIN_Y0) && (ay32 < WIN_Y0 + WIN_H);
  assign brd0    = (wx32 < BORDER) || (wx32 >= WIN_W - BORDER) ||
                   (wy32 < BORDER) || (wy32 >= WIN_H - BORDER);
  assign rd0     = win0 && mode_reg[0];
  assign addr0   = rd0 ? ADDR_W'(wy32 * WIN_W + wx32) : '0;

  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
    assign bar_edge[gi-1] = (ax32 >= gi * BAR_W);
  end
  assign bar0 = 3'($countones(bar_edge));

  // Stage 1: RAM request plus the flags that travel alongside it
  logic       act1, hs1, vs1, fs1, win1, brd1;
  logic [2:0] bar1;

  always_ff @(posedge clk_n or negedge reset) begin
    if (!reset) begin
      rd_en <= 1'b0;
      addr  <= '0;
      act1  <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      fs1   <= 1'b0;
      win1  <= 1'b0;
      brd1  <= 1'b0;
      bar1  <= 3'd0;
    end else if (tick) begin
      rd_en <= rd0;
      addr  <= addr0;
      act1  <= active0;
      hs1   <= hs0;
      vs1   <= vs0;
      fs1   <= fs0;
      win1  <= win0;
      brd1  <= brd0;
      bar1  <= bar0;
    end
  end

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  logic [23:0] rgb_next;

  always_comb begin
    rgb_next = 24'h000000;
    if (act1) begin
      case (mode_reg)
        2'b01:   if (win1) rgb_next = pix_data;
        2'b10:   rgb_next = bar_colour(bar1);
        2'b11:   if (win1) rgb_next = brd1 ? 24'hFFFFFF : pix_data;
        default: rgb_next = 24'h000000;
      endcase
    end
  end

  // Stage 2: all video outputs registered together so they stay aligned
  always_ff @(posedge clk_n or negedge reset) begin
    if (!reset) begin
      hsync       <= ~SPOL;
      vsync       <= ~SPOL;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      rgb_r       <= 8'd0;
      rgb_g       <= 8'd0;
      rgb_b       <= 8'd0;
    end else if (tick) begin
      hsync                 <= hs1 ~^ SPOL;
      vsync                 <= vs1 ~^ SPOL;
      vga_blank_n           <= act1;
      frame_start           <= fs1;
      {rgb_r, rgb_g, rgb_b} <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga_window_timing_gen.sv
// Directed bench for vga_window_timing_gen on a shrunken 48x27-tick raster
// (active 32x20, window 8x6 at (4,3), bars 4 px wide, border 2 px).
module tb_vga_window_timing_gen;

  localparam int FRAME = 1296;  // 48 ticks * 27 lines

  logic        clk_n = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] pix_data = 24'h0;
  logic        pix_en, hsync, vsync, vga_blank_n, vga_sync_n, rd_en, frame_start;
  logic [5:0]  addr;
  logic [7:0]  rgb_r, rgb_g, rgb_b;

  int checks = 0;
  int errors = 0;

  bit          use_ram = 1'b0;
  logic [23:0] pix_const = 24'h0;

  logic [23:0] cap_rgb [0:FRAME-1];
  logic        cap_hs  [0:FRAME-1];
  logic        cap_vs  [0:FRAME-1];
  logic        cap_bl  [0:FRAME-1];
  logic        cap_fs  [0:FRAME-1];
  logic        cap_rd  [0:FRAME-1];
  logic [5:0]  cap_addr[0:FRAME-1];

  vga_window_timing_gen #(
    .CLK_DIV(2), .H_FRONT(4), .H_SYNC(6), .H_BACK(6), .H_ACT(32),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .V_ACT(20), .SYNC_POL(0),
    .WIN_X0(4), .WIN_Y0(3), .WIN_W(8), .WIN_H(6), .ADDR_W(6), .BORDER(2)
  ) dut (
    .clk_n(clk_n), .reset(reset), .mode(mode), .pix_data(pix_data),
    .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .rd_en(rd_en), .addr(addr),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .frame_start(frame_start)
  );

  always #5 clk_n = ~clk_n;

  // Frame-buffer model: data tagged with the address it was read from
  always @(posedge clk_n) begin
    if (use_ram) begin
      if (rd_en) pix_data <= {8'hA5, 10'd0, addr};
    end else begin
      pix_data <= pix_const;
    end
  end

  task automatic next_pix();
    int n;
    n = 0;
    do begin
      @(negedge clk_n);
      n++;
    end while (pix_en !== 1'b1 && n < 8);
    if (pix_en !== 1'b1) begin
      checks++; errors++;
      $display("FAIL pix_en_timeout: pix_en=%b after %0d clocks, required 1", pix_en, n);
    end
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      next_pix();
      n++;
    end while (frame_start !== 1'b1 && n < 3000);
    if (frame_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL frame_start_timeout: frame_start=%b after %0d ticks, required 1", frame_start, n);
    end
  endtask

  // Sample p is pixel p of the frame; rd_en/addr lead by one tick, so store them one slot later
  task automatic capture_frame();
    cap_rd[0] = 1'b0;
    cap_addr[0] = '0;
    sync_frame();
    for (int p = 0; p < FRAME; p++) begin
      if (p > 0) next_pix();
      cap_rgb[p] = {rgb_r, rgb_g, rgb_b};
      cap_hs[p]  = hsync;
      cap_vs[p]  = vsync;
      cap_bl[p]  = vga_blank_n;
      cap_fs[p]  = frame_start;
      if (p < FRAME - 1) begin
        cap_rd[p+1]   = rd_en;
        cap_addr[p+1] = addr;
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    repeat (3) @(negedge clk_n);
    checks++;
    if ({pix_en, hsync, vsync, vga_blank_n, vga_sync_n, rd_en, frame_start} !== 7'b0110100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 0110100 (pix_en,hs,vs,blank_n,sync_n,rd_en,fs)",
               {pix_en, hsync, vsync, vga_blank_n, vga_sync_n, rd_en, frame_start});
    end
    checks++;
    if ({rgb_r, rgb_g, rgb_b, addr} !== 30'h0) begin
      errors++;
      $display("FAIL reset_data: rgb=%h addr=%h, expected 0", {rgb_r, rgb_g, rgb_b}, addr);
    end
    reset = 1'b1;
    @(negedge clk_n);
    @(negedge clk_n);
    checks++;
    if ({pix_en, frame_start} !== 2'b10) begin
      errors++;
      $display("FAIL first_tick: pix_en,fs=%b, expected 10", {pix_en, frame_start});
    end
    @(negedge clk_n);
    @(negedge clk_n);
    checks++;
    if ({pix_en, frame_start} !== 2'b11) begin
      errors++;
      $display("FAIL first_frame_start: pix_en,fs=%b, expected 11", {pix_en, frame_start});
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_n);
      if (pix_en === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 10) begin
      errors++;
      $display("FAIL pix_en_rate: %0d pulses in 20 clocks, expected 10", cnt);
    end
  endtask

  task automatic test_timing();
    int hs_line, hs_tot, vs_tot, bl_tot, fs_tot, nz;
    mode = 2'b00;
    capture_frame();
    hs_line = 0; hs_tot = 0; vs_tot = 0; bl_tot = 0; fs_tot = 0; nz = 0;
    for (int p = 0; p < FRAME; p++) begin
      if (p < 48 && cap_hs[p] === 1'b0) hs_line++;
      if (cap_hs[p] === 1'b0) hs_tot++;
      if (cap_vs[p] === 1'b0) vs_tot++;
      if (cap_bl[p] === 1'b1) bl_tot++;
      if (cap_fs[p] === 1'b1) fs_tot++;
      if (cap_rgb[p] !== 24'h0) nz++;
    end
    checks++;
    if (hs_line != 6 || hs_tot != 162) begin
      errors++;
      $display("FAIL hsync_width: line %0d total %0d, expected 6 and 162", hs_line, hs_tot);
    end
    checks++;
    if ({cap_hs[3], cap_hs[4], cap_hs[9], cap_hs[10], cap_hs[51], cap_hs[52]} !== 6'b100110) begin
      errors++;
      $display("FAIL hsync_edges: got %b, expected 100110 at h=3,4,9,10 and line1 h=3,4",
               {cap_hs[3], cap_hs[4], cap_hs[9], cap_hs[10], cap_hs[51], cap_hs[52]});
    end
    checks++;
    if (vs_tot != 96 || {cap_vs[95], cap_vs[96], cap_vs[191], cap_vs[192]} !== 4'b1001) begin
      errors++;
      $display("FAIL vsync: total %0d edges %b, expected 96 and 1001", vs_tot,
               {cap_vs[95], cap_vs[96], cap_vs[191], cap_vs[192]});
    end
    checks++;
    if (bl_tot != 640 || {cap_bl[351], cap_bl[352], cap_bl[304]} !== 3'b010) begin
      errors++;
      $display("FAIL blank_n: active %0d edges %b, expected 640 and 010", bl_tot,
               {cap_bl[351], cap_bl[352], cap_bl[304]});
    end
    checks++;
    if (fs_tot != 1 || cap_fs[0] !== 1'b1 || nz != 0) begin
      errors++;
      $display("FAIL frame_mode0: fs count %0d fs0 %b nonzero rgb %0d, expected 1 1 0", fs_tot, cap_fs[0], nz);
    end
    next_pix();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_length: frame_start=%b at tick 1296, expected 1", frame_start);
    end
  endtask

  task automatic test_image();
    int cnt, first, last;
    mode = 2'b01;
    use_ram = 1'b1;
    capture_frame();
    capture_frame();
    cnt = 0; first = -1; last = -1;
    for (int p = 0; p < FRAME; p++) begin
      if (cap_rd[p] === 1'b1) begin
        cnt++;
        if (first < 0) first = p;
        last = p;
      end
    end
    checks++;
    if (cnt != 48 || first != 500 || last != 747) begin
      errors++;
      $display("FAIL rd_en_span: count %0d first %0d last %0d, expected 48 500 747", cnt, first, last);
    end
    checks++;
    if ({cap_addr[500], cap_addr[501], cap_addr[548], cap_addr[747], cap_addr[499]} !==
        {6'd0, 6'd1, 6'd8, 6'd47, 6'd0}) begin
      errors++;
      $display("FAIL addr: got %0d %0d %0d %0d %0d, expected 0 1 8 47 0",
               cap_addr[500], cap_addr[501], cap_addr[548], cap_addr[747], cap_addr[499]);
    end
    checks++;
    if (cap_rgb[500] !== 24'hA50000 || cap_rgb[501] !== 24'hA50001 || cap_rgb[747] !== 24'hA5002F) begin
      errors++;
      $display("FAIL image_rgb: got %h %h %h, expected a50000 a50001 a5002f",
               cap_rgb[500], cap_rgb[501], cap_rgb[747]);
    end
    checks++;
    if (cap_rgb[499] !== 24'h0 || cap_rgb[748] !== 24'h0) begin
      errors++;
      $display("FAIL image_outside: got %h %h, expected 0 0", cap_rgb[499], cap_rgb[748]);
    end
  endtask

  task automatic test_border();
    mode = 2'b11;
    use_ram = 1'b0;
    pix_const = 24'h123456;
    capture_frame();
    capture_frame();
    checks++;
    if (cap_rgb[500] !== 24'hFFFFFF || cap_rgb[747] !== 24'hFFFFFF ||
        cap_rgb[645] !== 24'hFFFFFF || cap_rgb[602] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL border: got %h %h %h %h, expected ffffff x4",
               cap_rgb[500], cap_rgb[747], cap_rgb[645], cap_rgb[602]);
    end
    checks++;
    if (cap_rgb[598] !== 24'h123456 || cap_rgb[649] !== 24'h123456 || cap_rgb[499] !== 24'h0) begin
      errors++;
      $display("FAIL border_inner: got %h %h %h, expected 123456 123456 0",
               cap_rgb[598], cap_rgb[649], cap_rgb[499]);
    end
  endtask

  task automatic test_bars();
    int cnt;
    mode = 2'b10;
    capture_frame();
    capture_frame();
    checks++;
    if ({cap_rgb[352], cap_rgb[356], cap_rgb[360], cap_rgb[372]} !==
        {24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF0000}) begin
      errors++;
      $display("FAIL bars_left: got %h %h %h %h, expected ffffff ffff00 00ffff ff0000",
               cap_rgb[352], cap_rgb[356], cap_rgb[360], cap_rgb[372]);
    end
    checks++;
    if (cap_rgb[379] !== 24'h0000FF || cap_rgb[380] !== 24'h0 || cap_rgb[383] !== 24'h0) begin
      errors++;
      $display("FAIL bars_right: got %h %h %h, expected 0000ff 0 0", cap_rgb[379], cap_rgb[380], cap_rgb[383]);
    end
    checks++;
    if (cap_rgb[351] !== 24'h0 || cap_rgb[304] !== 24'h0) begin
      errors++;
      $display("FAIL bars_blank: got %h %h, expected 0 0", cap_rgb[351], cap_rgb[304]);
    end
    cnt = 0;
    for (int p = 0; p < FRAME; p++) if (cap_rd[p] === 1'b1) cnt++;
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL bars_rd_en: %0d reads, expected 0", cnt);
    end
  endtask

  task automatic test_mode_switch();
    sync_frame();
    for (int p = 1; p <= 836; p++) begin
      next_pix();
      if (p == 576) mode = 2'b01;
    end
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== 24'hFFFF00) begin
      errors++;
      $display("FAIL switch_same_frame: got %h, expected ffff00", {rgb_r, rgb_g, rgb_b});
    end
    use_ram = 1'b1;
    capture_frame();
    checks++;
    if (cap_rgb[500] !== 24'hA50000 || cap_rd[500] !== 1'b1 || cap_rgb[352] !== 24'h0) begin
      errors++;
      $display("FAIL switch_next_frame: rgb %h rd %b rgb(0,0) %h, expected a50000 1 0",
               cap_rgb[500], cap_rd[500], cap_rgb[352]);
    end
  endtask

  task automatic test_reset_mid_line();
    sync_frame();
    for (int p = 1; p <= 501; p++) next_pix();
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== 24'hA50001 || rd_en !== 1'b1 || addr !== 6'd2) begin
      errors++;
      $display("FAIL pre_reset: rgb %h rd %b addr %0d, expected a50001 1 2", {rgb_r, rgb_g, rgb_b}, rd_en, addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({pix_en, hsync, vsync, vga_blank_n, rd_en, frame_start} !== 6'b011000 ||
        {rgb_r, rgb_g, rgb_b, addr} !== 30'h0) begin
      errors++;
      $display("FAIL async_reset: ctrl %b rgb %h addr %0d, expected 011000 0 0",
               {pix_en, hsync, vsync, vga_blank_n, rd_en, frame_start}, {rgb_r, rgb_g, rgb_b}, addr);
    end
    repeat (3) @(negedge clk_n);
    reset = 1'b1;
    @(negedge clk_n);
    @(negedge clk_n);
    checks++;
    if ({pix_en, frame_start} !== 2'b10) begin
      errors++;
      $display("FAIL restart_tick1: pix_en,fs=%b, expected 10", {pix_en, frame_start});
    end
    @(negedge clk_n);
    @(negedge clk_n);
    checks++;
    if ({pix_en, frame_start} !== 2'b11) begin
      errors++;
      $display("FAIL restart_origin: pix_en,fs=%b, expected 11", {pix_en, frame_start});
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_image();
    test_border();
    test_bars();
    test_mode_switch();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
